// File: rtl/hskbus_uart_pkg.sv
// Shared types and defaults for the housekeeping-bus UART receive monitor.
package hskbus_uart_pkg;

  localparam int HSKBUS_CLKS_PER_BIT = 160;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/hskbus_bit_sync.sv
// Multi-flop single-bit synchronizer with a configurable reset level.
module hskbus_bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hskbus_uart_rx_mon.sv
// 8N1 UART byte receiver/monitor for the hskbus line: mid-bit sampling,
// framing-error detection, break hold-off and wrapping byte/error counters.
module hskbus_uart_rx_mon
  import hskbus_uart_pkg::*;
#(
  parameter int    CLKS_PER_BIT = HSKBUS_CLKS_PER_BIT,
  parameter string SYNC_INPUT   = "TRUE"
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic [7:0] byte_count_o,
  output logic [7:0] ferr_count_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  generate
    if (SYNC_INPUT == "TRUE") begin : g_sync
      hskbus_bit_sync #(
        .STAGES   (2),
        .RESET_VAL(1'b1)
      ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (rx_i),
        .q_o  (rx_s)
      );
    end else begin : g_bypass
      assign rx_s = rx_i;
    end
  endgenerate

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [7:0]       fcnt_q, fcnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = FULL_LOAD;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = FULL_LOAD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_q == '0) begin
          if (rx_s) begin
            byte_d  = shreg_q;
            valid_d = 1'b1;
            bcnt_d  = bcnt_q + 8'd1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BREAK: begin
        // A held-low line must rise before another start bit is accepted.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      bcnt_q  <= 8'h00;
      fcnt_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != IDLE);
  assign byte_count_o = bcnt_q;
  assign ferr_count_o = fcnt_q;

endmodule

// File: tb/tb_hskbus_uart_rx_mon.sv
// Scoreboard bench for hskbus_uart_rx_mon: frames are queued as they are
// driven and matched, including strobe cycle, when the receiver reports them.
`timescale 1ns/1ps
module tb_hskbus_uart_rx_mon;

  localparam int CPB = 16;
  // Strobe cycle relative to the first edge that samples the start bit low.
  localparam int STROBE_OFS = 2 + CPB / 2 + 9 * CPB;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i  = 1'b1;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       frame_err_o;
  logic       busy_o;
  logic [7:0] byte_count_o;
  logic [7:0] ferr_count_o;

  hskbus_uart_rx_mon #(
    .CLKS_PER_BIT(CPB),
    .SYNC_INPUT  ("TRUE")
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o),
    .byte_count_o(byte_count_o),
    .ferr_count_o(ferr_count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  exp_t       byte_q[$];
  exp_t       ferr_q[$];
  logic [7:0] exp_bcnt = 8'h00;
  logic [7:0] exp_fcnt = 8'h00;
  logic [7:0] exp_last = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every strobe.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (byte_valid_o && frame_err_o) begin
        check("both_strobes", 32'd1, 32'd0);
      end else if (byte_valid_o) begin
        if (byte_q.size() == 0) begin
          check("spurious_byte", {24'd0, byte_o}, 32'hffff_ffff);
        end else begin
          e = byte_q.pop_front();
          exp_bcnt = exp_bcnt + 8'd1;
          exp_last = e.data;
          check("byte", {24'd0, byte_o}, {24'd0, e.data});
          check("byte_count", {24'd0, byte_count_o}, {24'd0, exp_bcnt});
          check("ferr_count_on_byte", {24'd0, ferr_count_o}, {24'd0, exp_fcnt});
          if (e.due >= 0) check("byte_cycle", cyc, e.due);
        end
      end else if (frame_err_o) begin
        if (ferr_q.size() == 0) begin
          check("spurious_ferr", 32'd1, 32'd0);
        end else begin
          e = ferr_q.pop_front();
          exp_fcnt = exp_fcnt + 8'd1;
          check("ferr_count", {24'd0, ferr_count_o}, {24'd0, exp_fcnt});
          check("byte_held_on_ferr", {24'd0, byte_o}, {24'd0, exp_last});
          check("byte_count_on_ferr", {24'd0, byte_count_o}, {24'd0, exp_bcnt});
          if (e.due >= 0) check("ferr_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic hold(input logic val, input int n);
    rx_i = val;
    repeat (n) @(negedge clk_i);
  endtask

  // Drives one 8N1 frame; bit boundaries follow scale (1.0 = nominal baud).
  task automatic send_frame(input logic [7:0] d, input logic stop, input real scale);
    logic [9:0] bits;
    exp_t       e;
    int         t;
    bits   = {stop, d, 1'b0};
    e.data = d;
    e.due  = (scale == 1.0) ? (cyc + 1 + STROBE_OFS) : -1;
    if (stop) byte_q.push_back(e);
    else      ferr_q.push_back(e);
    t = 0;
    for (int k = 0; k < 10; k++) begin
      rx_i = bits[k];
      while (t < $rtoi(real'((k + 1) * CPB) * scale + 0.5)) begin
        @(negedge clk_i);
        t++;
      end
    end
    rx_i = 1'b1;
  endtask

  task automatic pulse_reset(input string tag);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    @(negedge clk_i);
    check({tag, "_byte"}, {24'd0, byte_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, byte_valid_o}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_bcnt"}, {24'd0, byte_count_o}, 32'd0);
    check({tag, "_fcnt"}, {24'd0, ferr_count_o}, 32'd0);
    byte_q.delete();
    ferr_q.delete();
    exp_bcnt = 8'h00;
    exp_fcnt = 8'h00;
    exp_last = 8'h00;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((byte_q.size() + ferr_q.size()) != 0 && guard < 20 * CPB) begin
      @(negedge clk_i);
      guard++;
    end
    check(tag, byte_q.size() + ferr_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    pulse_reset("rst0");
    hold(1'b1, 2 * CPB);

    // Single nominal frame.
    send_frame(8'hA5, 1'b1, 1.0);
    drain("a5_drain");
    check("a5_bcnt", {24'd0, byte_count_o}, 32'd1);
    check("a5_fcnt", {24'd0, ferr_count_o}, 32'd0);

    // Back-to-back frames, one stop bit each.
    send_frame(8'h00, 1'b1, 1.0);
    send_frame(8'hFF, 1'b1, 1.0);
    send_frame(8'h3C, 1'b1, 1.0);
    drain("b2b_drain");
    check("b2b_bcnt", {24'd0, byte_count_o}, 32'd4);

    // Short low glitch on an idle line: START must abort silently.
    hold(1'b0, CPB / 4);
    hold(1'b1, 2);
    check("glitch_busy_in_start", {31'd0, busy_o}, 32'd1);
    hold(1'b1, 2 * CPB);
    check("glitch_busy_cleared", {31'd0, busy_o}, 32'd0);
    check("glitch_bcnt", {24'd0, byte_count_o}, {24'd0, exp_bcnt});
    check("glitch_fcnt", {24'd0, ferr_count_o}, {24'd0, exp_fcnt});

    // Stop bit low then a long break: one framing error only.
    send_frame(8'h55, 1'b0, 1.0);
    hold(1'b0, 30 * CPB);
    check("break_busy", {31'd0, busy_o}, 32'd1);
    check("break_fcnt", {24'd0, ferr_count_o}, 32'd1);
    hold(1'b1, CPB);
    check("break_released", {31'd0, busy_o}, 32'd0);
    send_frame(8'h12, 1'b1, 1.0);
    drain("break_drain");
    check("post_break_byte", {24'd0, byte_o}, 32'h12);

    // Reset during data bit 4.
    hold(1'b0, CPB);
    for (int k = 0; k < 4; k++) hold(k[0], CPB);
    hold(1'b0, CPB / 2);
    pulse_reset("rst_mid");
    hold(1'b1, 20 * CPB);
    check("rst_mid_no_strobe_bcnt", {24'd0, byte_count_o}, 32'd0);
    send_frame(8'h81, 1'b1, 1.0);
    drain("post_rst_drain");
    check("post_rst_byte", {24'd0, byte_o}, 32'h81);

    // Full byte sweep at +3% baud (low half) and -3% baud (high half).
    pulse_reset("rst_sweep");
    hold(1'b1, 2 * CPB);
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1, (v < 128) ? (1.0 / 1.03) : 1.03);
    end
    drain("sweep_drain");
    check("sweep_wrap_bcnt", {24'd0, byte_count_o}, 32'd0);
    check("sweep_fcnt", {24'd0, ferr_count_o}, 32'd0);
    check("sweep_last_byte", {24'd0, byte_o}, 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
